// File: rtl/decode_queue.sv
// RV32I decode stage feeding a DEPTH-entry record FIFO between fetch and dispatch.
// Optional feature macro: DECODER_ILLEGAL_CHECK_EN (queue illegal words flagged on out_illegal).
module decode_queue #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_ins,
   input  logic [31:0]      in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [5:0]       out_opcode,
   output logic [6:0]       out_ophead,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [4:0]       out_rd,
   output logic [31:0]      out_imm,
   output logic [31:0]      out_pc,
`ifdef DECODER_ILLEGAL_CHECK_EN
   output logic             out_illegal,
`endif
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   // Internal opcode encoding; 0 is reserved for "no operation / illegal".
   localparam logic [5:0] OP_LUI   = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL   = 6'd3,  OP_JALR  = 6'd4;
   localparam logic [5:0] OP_BEQ   = 6'd5,  OP_BNE   = 6'd6,  OP_BLT   = 6'd7,  OP_BGE   = 6'd8;
   localparam logic [5:0] OP_BLTU  = 6'd9,  OP_BGEU  = 6'd10, OP_LB    = 6'd11, OP_LH    = 6'd12;
   localparam logic [5:0] OP_LW    = 6'd13, OP_LBU   = 6'd14, OP_LHU   = 6'd15, OP_SB    = 6'd16;
   localparam logic [5:0] OP_SH    = 6'd17, OP_SW    = 6'd18, OP_ADDI  = 6'd19, OP_SLTI  = 6'd20;
   localparam logic [5:0] OP_SLTIU = 6'd21, OP_XORI  = 6'd22, OP_ORI   = 6'd23, OP_ANDI  = 6'd24;
   localparam logic [5:0] OP_SLLI  = 6'd25, OP_SRLI  = 6'd26, OP_SRAI  = 6'd27, OP_ADD   = 6'd28;
   localparam logic [5:0] OP_SUB   = 6'd29, OP_SLL   = 6'd30, OP_SLT   = 6'd31, OP_SLTU  = 6'd32;
   localparam logic [5:0] OP_XOR   = 6'd33, OP_SRL   = 6'd34, OP_SRA   = 6'd35, OP_OR    = 6'd36;
   localparam logic [5:0] OP_AND   = 6'd37;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [6:0]  ophead;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [31:0] pc;
`ifdef DECODER_ILLEGAL_CHECK_EN
      logic        illegal;
`endif
   } rec_t;

   rec_t             r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;

   logic [6:0]  w_major;
   logic [2:0]  w_funct3;
   logic [6:0]  w_funct7;
   logic [31:0] w_immI, w_immSh, w_immS, w_immB, w_immU, w_immJ;
   logic [5:0]  w_opcode;
   logic [31:0] w_imm;
   logic        w_bad;
   rec_t        w_rec;
   rec_t        w_head;
   logic        w_enq, w_deq, w_push;

   assign w_major  = in_ins[6:0];
   assign w_funct3 = in_ins[14:12];
   assign w_funct7 = in_ins[31:25];
   assign w_immI   = {{20{in_ins[31]}}, in_ins[31:20]};
   assign w_immSh  = {27'b0, in_ins[24:20]};
   assign w_immS   = {{20{in_ins[31]}}, in_ins[31:25], in_ins[11:7]};
   assign w_immB   = {{19{in_ins[31]}}, in_ins[31], in_ins[7], in_ins[30:25], in_ins[11:8], 1'b0};
   assign w_immU   = {in_ins[31:12], 12'b0};
   assign w_immJ   = {{11{in_ins[31]}}, in_ins[31], in_ins[19:12], in_ins[20], in_ins[30:21], 1'b0};

   // Major opcode selects format; funct3/funct7 pick the operation, anything reserved is bad.
   always_comb begin
      w_opcode = 6'd0;
      w_imm    = 32'd0;
      w_bad    = 1'b0;
      unique case (w_major)
         7'b0110111: begin w_opcode = OP_LUI;   w_imm = w_immU; end
         7'b0010111: begin w_opcode = OP_AUIPC; w_imm = w_immU; end
         7'b1101111: begin w_opcode = OP_JAL;   w_imm = w_immJ; end
         7'b1100111: begin
            w_opcode = OP_JALR;
            w_imm    = w_immI;
            w_bad    = (w_funct3 != 3'b000);
         end
         7'b1100011: begin
            w_imm = w_immB;
            case (w_funct3)
               3'b000:  w_opcode = OP_BEQ;
               3'b001:  w_opcode = OP_BNE;
               3'b100:  w_opcode = OP_BLT;
               3'b101:  w_opcode = OP_BGE;
               3'b110:  w_opcode = OP_BLTU;
               3'b111:  w_opcode = OP_BGEU;
               default: w_bad = 1'b1;
            endcase
         end
         7'b0000011: begin
            w_imm = w_immI;
            case (w_funct3)
               3'b000:  w_opcode = OP_LB;
               3'b001:  w_opcode = OP_LH;
               3'b010:  w_opcode = OP_LW;
               3'b100:  w_opcode = OP_LBU;
               3'b101:  w_opcode = OP_LHU;
               default: w_bad = 1'b1;
            endcase
         end
         7'b0100011: begin
            w_imm = w_immS;
            case (w_funct3)
               3'b000:  w_opcode = OP_SB;
               3'b001:  w_opcode = OP_SH;
               3'b010:  w_opcode = OP_SW;
               default: w_bad = 1'b1;
            endcase
         end
         7'b0010011: begin
            w_imm = w_immI;
            case (w_funct3)
               3'b000: w_opcode = OP_ADDI;
               3'b010: w_opcode = OP_SLTI;
               3'b011: w_opcode = OP_SLTIU;
               3'b100: w_opcode = OP_XORI;
               3'b110: w_opcode = OP_ORI;
               3'b111: w_opcode = OP_ANDI;
               3'b001: begin
                  w_imm    = w_immSh;
                  w_opcode = OP_SLLI;
                  w_bad    = (w_funct7 != 7'b0000000);
               end
               default: begin
                  w_imm = w_immSh;
                  if (w_funct7 == 7'b0000000)      w_opcode = OP_SRLI;
                  else if (w_funct7 == 7'b0100000) w_opcode = OP_SRAI;
                  else                             w_bad    = 1'b1;
               end
            endcase
         end
         7'b0110011: begin
            if (w_funct7 == 7'b0000000) begin
               case (w_funct3)
                  3'b000:  w_opcode = OP_ADD;
                  3'b001:  w_opcode = OP_SLL;
                  3'b010:  w_opcode = OP_SLT;
                  3'b011:  w_opcode = OP_SLTU;
                  3'b100:  w_opcode = OP_XOR;
                  3'b101:  w_opcode = OP_SRL;
                  3'b110:  w_opcode = OP_OR;
                  default: w_opcode = OP_AND;
               endcase
            end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
               w_opcode = OP_SUB;
            end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b101) begin
               w_opcode = OP_SRA;
            end else begin
               w_bad = 1'b1;
            end
         end
         default: w_bad = 1'b1;
      endcase
      if (w_bad) begin
         w_opcode = 6'd0;
         w_imm    = 32'd0;
      end
   end

   always_comb begin
      w_rec        = '0;
      w_rec.opcode = w_opcode;
      w_rec.ophead = in_ins[6:0];
      w_rec.rs1    = in_ins[19:15];
      w_rec.rs2    = in_ins[24:20];
      w_rec.rd     = in_ins[11:7];
      w_rec.imm    = w_imm;
      w_rec.pc     = in_pc;
`ifdef DECODER_ILLEGAL_CHECK_EN
      w_rec.illegal = w_bad;
`endif
   end

   assign in_ready  = (r_count != CNT_W'(DEPTH));
   assign out_valid = (r_count != '0);
   assign count     = r_count;
   assign w_enq     = in_valid && in_ready;
   assign w_deq     = out_valid && out_ready;
`ifdef DECODER_ILLEGAL_CHECK_EN
   assign w_push    = w_enq;
`else
   // Illegal words complete the handshake but are silently dropped.
   assign w_push    = w_enq && !w_bad;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (rdy) begin
         if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
         end else begin
            if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_deq)  r_rdPtr <= r_rdPtr + PTR_W'(1);
            case ({w_push, w_deq})
               2'b10:   r_count <= r_count + CNT_W'(1);
               2'b01:   r_count <= r_count - CNT_W'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && rdy && !flush && w_push) r_mem[r_wrPtr] <= w_rec;
   end

   assign w_head = r_mem[r_rdPtr];

   // Payload is forced to zero whenever no head record is valid.
   always_comb begin
      out_opcode = '0;
      out_ophead = '0;
      out_rs1    = '0;
      out_rs2    = '0;
      out_rd     = '0;
      out_imm    = '0;
      out_pc     = '0;
`ifdef DECODER_ILLEGAL_CHECK_EN
      out_illegal = 1'b0;
`endif
      if (out_valid) begin
         out_opcode = w_head.opcode;
         out_ophead = w_head.ophead;
         out_rs1    = w_head.rs1;
         out_rs2    = w_head.rs2;
         out_rd     = w_head.rd;
         out_imm    = w_head.imm;
         out_pc     = w_head.pc;
`ifdef DECODER_ILLEGAL_CHECK_EN
         out_illegal = w_head.illegal;
`endif
      end
   end

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard testbench for decode_queue: directed RV32I words, a monitor compares every dequeued record.
module tb_decode_queue;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   localparam logic [5:0] OP_LUI  = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL = 6'd3,  OP_BEQ = 6'd5;
   localparam logic [5:0] OP_LW   = 6'd13, OP_SW    = 6'd18, OP_ADDI = 6'd19;
   localparam logic [5:0] OP_SRAI = 6'd27, OP_SUB   = 6'd29;

   typedef struct {
      logic [5:0]  opcode;
      logic [6:0]  ophead;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        illegal;
   } exp_t;

   exp_t expQ[$];
   exp_t mExp;
   int   vectors = 0;
   int   miscompares = 0;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             rdy = 1'b1;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_ins = 32'd0;
   logic [31:0]      in_pc = 32'd0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [5:0]       out_opcode;
   logic [6:0]       out_ophead;
   logic [4:0]       out_rs1, out_rs2, out_rd;
   logic [31:0]      out_imm, out_pc;
   logic [CNT_W-1:0] count;
`ifdef DECODER_ILLEGAL_CHECK_EN
   logic             out_illegal;
`endif

   decode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_ophead(out_ophead),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_imm(out_imm), .out_pc(out_pc),
`ifdef DECODER_ILLEGAL_CHECK_EN
      .out_illegal(out_illegal),
`endif
      .count(count)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Safety net so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected $finish before 100000");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Record the expected head record for a word that the queue will accept.
   task automatic pushExp(input logic [31:0] ins, input logic [31:0] pc,
                          input logic [5:0] opcode, input logic [31:0] imm, input logic illegal);
      exp_t e;
      e.opcode  = opcode;
      e.ophead  = ins[6:0];
      e.rs1     = ins[19:15];
      e.rs2     = ins[24:20];
      e.rd      = ins[11:7];
      e.imm     = imm;
      e.pc      = pc;
      e.illegal = illegal;
      expQ.push_back(e);
   endtask

   // Drive one cycle of handshake inputs, then sit just after the rising edge.
   task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic ordy);
      in_valid  = v;
      in_ins    = ins;
      in_pc     = pc;
      out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   // Monitor: a dequeue will happen at the next edge, so compare the head against the scoreboard.
   always @(negedge clk) begin
      if (!rst && rdy && !flush && out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_record: got pc 0x%08h, expected no record", out_pc);
         end else begin
            mExp = expQ.pop_front();
            checkOutput("head_opcode", 32'(out_opcode), 32'(mExp.opcode));
            checkOutput("head_ophead", 32'(out_ophead), 32'(mExp.ophead));
            checkOutput("head_rs1",    32'(out_rs1),    32'(mExp.rs1));
            checkOutput("head_rs2",    32'(out_rs2),    32'(mExp.rs2));
            checkOutput("head_rd",     32'(out_rd),     32'(mExp.rd));
            checkOutput("head_imm",    out_imm,         mExp.imm);
            checkOutput("head_pc",     out_pc,          mExp.pc);
`ifdef DECODER_ILLEGAL_CHECK_EN
            checkOutput("head_illegal", 32'(out_illegal), 32'(mExp.illegal));
`endif
         end
      end
   end

   logic [31:0] fmtIns [6];
   logic [5:0]  fmtOp  [6];
   logic [31:0] fmtImm [6];
   logic [31:0] w;

   initial begin
      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset_count",     32'(count),      32'd0);
      checkOutput("reset_in_ready",  32'(in_ready),   32'd1);
      checkOutput("reset_out_valid", 32'(out_valid),  32'd0);
      checkOutput("reset_opcode",    32'(out_opcode), 32'd0);
      checkOutput("reset_imm",       out_imm,         32'd0);

      // ADDI x1,x0,5 then empty queue shows zero payload.
      pushExp(32'h00500093, 32'h100, OP_ADDI, 32'h5, 1'b0);
      applyStimulus(1'b1, 32'h00500093, 32'h100, 1'b1);
      in_valid = 1'b0;
      checkOutput("addi_out_valid", 32'(out_valid), 32'd1);
      checkOutput("addi_count",     32'(count),     32'd1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
      checkOutput("empty_out_valid", 32'(out_valid),  32'd0);
      checkOutput("empty_opcode",    32'(out_opcode), 32'd0);
      checkOutput("empty_rd",        32'(out_rd),     32'd0);
      checkOutput("empty_imm",       out_imm,         32'd0);
      checkOutput("empty_pc",        out_pc,          32'd0);

      // BEQ x0,x0,-4 and LUI x5,0x12345 streamed back to back.
      pushExp(32'hFE000EE3, 32'h104, OP_BEQ, 32'hFFFFFFFC, 1'b0);
      applyStimulus(1'b1, 32'hFE000EE3, 32'h104, 1'b1);
      pushExp(32'h123452B7, 32'h108, OP_LUI, 32'h12345000, 1'b0);
      applyStimulus(1'b1, 32'h123452B7, 32'h108, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
      checkOutput("stream_count", 32'(count), 32'd0);

      // One word per remaining immediate format: S, I(load), shift, R, J, U(auipc).
      fmtIns[0] = 32'hFE21AC23; fmtOp[0] = OP_SW;    fmtImm[0] = 32'hFFFFFFF8;
      fmtIns[1] = 32'hFFF2A203; fmtOp[1] = OP_LW;    fmtImm[1] = 32'hFFFFFFFF;
      fmtIns[2] = 32'h4033D313; fmtOp[2] = OP_SRAI;  fmtImm[2] = 32'h00000003;
      fmtIns[3] = 32'h40A48433; fmtOp[3] = OP_SUB;   fmtImm[3] = 32'h00000000;
      fmtIns[4] = 32'h008000EF; fmtOp[4] = OP_JAL;   fmtImm[4] = 32'h00000008;
      fmtIns[5] = 32'hFFFFF197; fmtOp[5] = OP_AUIPC; fmtImm[5] = 32'hFFFFF000;
      for (int i = 0; i < 6; i++) begin
         pushExp(fmtIns[i], 32'h140 + 32'(4 * i), fmtOp[i], fmtImm[i], 1'b0);
         applyStimulus(1'b1, fmtIns[i], 32'h140 + 32'(4 * i), 1'b1);
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
      checkOutput("formats_count", 32'(count), 32'd0);

      // Fill: six offers with out_ready low, only four fit.
      for (int i = 0; i < 6; i++) begin
         w = {12'(i + 1), 5'd0, 3'd0, 5'(i + 1), 7'h13};
         if (i < 4) pushExp(w, 32'h200 + 32'(4 * i), OP_ADDI, 32'(i + 1), 1'b0);
         applyStimulus(1'b1, w, 32'h200 + 32'(4 * i), 1'b0);
         if (i == 3) begin
            checkOutput("full_count",    32'(count),    32'd4);
            checkOutput("full_in_ready", 32'(in_ready), 32'd0);
         end
      end
      checkOutput("full_hold_count", 32'(count), 32'd4);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
      checkOutput("drain_count", 32'(count), 32'd0);

      // Pointers wrap again on four more pushes.
      for (int i = 0; i < 4; i++) begin
         w = {12'(i + 9), 5'd2, 3'd0, 5'd3, 7'h13};
         pushExp(w, 32'h240 + 32'(4 * i), OP_ADDI, 32'(i + 9), 1'b0);
         applyStimulus(1'b1, w, 32'h240 + 32'(4 * i), 1'b0);
      end
      checkOutput("wrap_count", 32'(count), 32'd4);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);

      // Simultaneous push and pop at count 2, then flush with a word offered.
      pushExp(32'h00A00093, 32'h300, OP_ADDI, 32'hA, 1'b0);
      applyStimulus(1'b1, 32'h00A00093, 32'h300, 1'b0);
      pushExp(32'h00B00093, 32'h304, OP_ADDI, 32'hB, 1'b0);
      applyStimulus(1'b1, 32'h00B00093, 32'h304, 1'b0);
      checkOutput("pair_count", 32'(count), 32'd2);
      pushExp(32'h00C00093, 32'h308, OP_ADDI, 32'hC, 1'b0);
      applyStimulus(1'b1, 32'h00C00093, 32'h308, 1'b1);
      checkOutput("pushpop_count", 32'(count), 32'd2);
      checkOutput("pushpop_head",  out_pc,     32'h304);
      flush = 1'b1;
      applyStimulus(1'b1, 32'h00D00093, 32'h30C, 1'b0);
      flush = 1'b0;
      expQ.delete();
      checkOutput("flush_count",     32'(count),     32'd0);
      checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
      checkOutput("flush_pc",        out_pc,         32'd0);
      pushExp(32'h00E00093, 32'h310, OP_ADDI, 32'hE, 1'b0);
      applyStimulus(1'b1, 32'h00E00093, 32'h310, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
      checkOutput("post_flush_count", 32'(count), 32'd0);

      // rdy low freezes everything even with both handshakes offered.
      pushExp(32'h01100093, 32'h400, OP_ADDI, 32'h11, 1'b0);
      applyStimulus(1'b1, 32'h01100093, 32'h400, 1'b0);
      pushExp(32'h01200093, 32'h404, OP_ADDI, 32'h12, 1'b0);
      applyStimulus(1'b1, 32'h01200093, 32'h404, 1'b0);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h01300093, 32'h408, 1'b1);
         checkOutput("frozen_count", 32'(count), 32'd2);
         checkOutput("frozen_pc",    out_pc,     32'h400);
         checkOutput("frozen_imm",   out_imm,    32'h11);
      end
      rdy = 1'b1;
      pushExp(32'h01400093, 32'h40C, OP_ADDI, 32'h14, 1'b0);
      applyStimulus(1'b1, 32'h01400093, 32'h40C, 1'b0);
      pushExp(32'h01500093, 32'h410, OP_ADDI, 32'h15, 1'b0);
      applyStimulus(1'b1, 32'h01500093, 32'h410, 1'b0);
      checkOutput("prereset_count", 32'(count), 32'd4);

      // Reset from a full queue.
      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
      rst = 1'b0;
      expQ.delete();
      checkOutput("midreset_count",     32'(count),     32'd0);
      checkOutput("midreset_in_ready",  32'(in_ready),  32'd1);
      checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);

      // Illegal words: all-ones and a reserved load funct3.
      checkOutput("illegal_in_ready", 32'(in_ready), 32'd1);
`ifdef DECODER_ILLEGAL_CHECK_EN
      pushExp(32'hFFFFFFFF, 32'h500, 6'd0, 32'd0, 1'b1);
      applyStimulus(1'b1, 32'hFFFFFFFF, 32'h500, 1'b0);
      checkOutput("illegal_count", 32'(count), 32'd1);
      pushExp(32'h00003003, 32'h504, 6'd0, 32'd0, 1'b1);
      applyStimulus(1'b1, 32'h00003003, 32'h504, 1'b0);
      checkOutput("reserved_count", 32'(count), 32'd2);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
`else
      applyStimulus(1'b1, 32'hFFFFFFFF, 32'h500, 1'b0);
      checkOutput("illegal_count",     32'(count),     32'd0);
      checkOutput("illegal_out_valid", 32'(out_valid), 32'd0);
      applyStimulus(1'b1, 32'h00003003, 32'h504, 1'b0);
      checkOutput("reserved_count", 32'(count), 32'd0);
`endif
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("final_count", 32'(count), 32'd0);
      checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
